// File: rtl/pipe_dmem_io.sv
// Data-memory responder for the pipeline CPU's data port: word RAM plus an I/O window
// (posted-write TX FIFO, synchronised switches, cycle counter). Loads return in the same cycle.
// Optional feature: define DMEM_IO_CYCLE_CNT_EN to build the free-running cycle counter;
// when undefined the CYCLE register reads as zero and no counter flops exist.
module pipe_dmem_io #(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned FIFO_LOG2 = 2,
    parameter int unsigned SW_W      = 16
) (
    input  logic            clock,
    input  logic            resetn,
    input  logic            mem_wmem,
    input  logic [31:0]     mem_aluo,
    input  logic [31:0]     mem_data,
    output logic [31:0]     mem,
    input  logic [SW_W-1:0] sw_in,
    output logic            io_valid,
    output logic [31:0]     io_data,
    input  logic            io_ready
);

    localparam int unsigned RamWords = 2 ** ADDR_W;
    localparam int unsigned Depth    = 2 ** FIFO_LOG2;

    typedef logic [FIFO_LOG2-1:0] ptr_t;
    typedef logic [FIFO_LOG2:0]   cnt_t;

    localparam ptr_t PtrOne  = ptr_t'(1);
    localparam cnt_t CntOne  = cnt_t'(1);
    localparam cnt_t CntFull = cnt_t'(Depth);

    localparam logic [1:0] OffTx     = 2'd0;
    localparam logic [1:0] OffStatus = 2'd1;
    localparam logic [1:0] OffSwitch = 2'd2;
    localparam logic [1:0] OffCycle  = 2'd3;

    // Address decode; bits [1:0] and the aliased upper bits are deliberately ignored
    logic              is_io;
    logic [1:0]        io_sel;
    logic [ADDR_W-1:0] ram_idx;
    logic              unused_addr;

    assign is_io       = mem_aluo[31];
    assign io_sel      = mem_aluo[3:2];
    assign ram_idx     = mem_aluo[ADDR_W+1:2];
    assign unused_addr = ^{mem_aluo[30:ADDR_W+2], mem_aluo[1:0]};

    // ------------------------------------------------------------------
    // RAM: synchronous write, asynchronous read (read-during-write sees old word)
    // ------------------------------------------------------------------
    logic [31:0] ram_q [RamWords];
    logic        ram_we;

    assign ram_we = mem_wmem & ~is_io;

    // RAM write port; contents survive reset
    always_ff @(posedge clock) begin
        if (ram_we) begin
            ram_q[ram_idx] <= mem_data;
        end
    end

    // ------------------------------------------------------------------
    // Switch synchroniser
    // ------------------------------------------------------------------
    logic [SW_W-1:0] sw_meta_q;
    logic [SW_W-1:0] sw_sync_q;

    // Two-flop synchroniser for the asynchronous switch levels
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sw_meta_q <= '0;
            sw_sync_q <= '0;
        end else begin
            sw_meta_q <= sw_in;
            sw_sync_q <= sw_meta_q;
        end
    end

    // ------------------------------------------------------------------
    // Cycle counter
    // ------------------------------------------------------------------
    logic [31:0] cyc_rd;

`ifdef DMEM_IO_CYCLE_CNT_EN
    logic [31:0] cyc_q;
    logic [31:0] cyc_d;

    assign cyc_d  = cyc_q + 32'd1;
    assign cyc_rd = cyc_q;

    // Free-running counter, wraps naturally at 2**32
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cyc_q <= '0;
        end else begin
            cyc_q <= cyc_d;
        end
    end
`else
    assign cyc_rd = '0;
`endif

    // ------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------
    logic [31:0] fifo_q [Depth];
    ptr_t        wr_ptr_q, wr_ptr_d;
    ptr_t        rd_ptr_q, rd_ptr_d;
    cnt_t        count_q, count_d;
    logic        ovf_q, ovf_d;

    logic push_req;
    logic push_ok;
    logic pop;
    logic full;
    logic ovf_clr;

    assign io_valid = (count_q != '0);
    assign io_data  = fifo_q[rd_ptr_q];
    assign pop      = io_valid & io_ready;
    assign full     = (count_q == CntFull);
    assign push_req = mem_wmem & is_io & (io_sel == OffTx);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push
    assign push_ok  = push_req & (~full | pop);
    assign ovf_clr  = mem_wmem & is_io & (io_sel == OffStatus) & mem_data[31];

    // FIFO pointer, occupancy and sticky-overflow next state
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;

        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PtrOne;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrOne;
        end

        case ({push_ok, pop})
            2'b10:   count_d = count_q + CntOne;
            2'b01:   count_d = count_q - CntOne;
            default: count_d = count_q;
        endcase

        if (ovf_clr) begin
            ovf_d = 1'b0;
        end else if (push_req && !push_ok) begin
            ovf_d = 1'b1;
        end
    end

    // FIFO control state; in-flight entries are discarded by resetting the pointers
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // FIFO storage write; entries are not reset
    always_ff @(posedge clock) begin
        if (push_ok) begin
            fifo_q[wr_ptr_q] <= mem_data;
        end
    end

    // ------------------------------------------------------------------
    // Load data mux
    // ------------------------------------------------------------------

    // Combinational load path from current address and state
    always_comb begin
        mem = '0;
        if (!is_io) begin
            mem = ram_q[ram_idx];
        end else begin
            case (io_sel)
                OffTx:     mem = '0;
                OffStatus: mem = {ovf_q, 15'b0, 16'(count_q)};
                OffSwitch: mem = 32'(sw_sync_q);
                OffCycle:  mem = cyc_rd;
                default:   mem = '0;
            endcase
        end
    end

endmodule
